mux_nto1_pipe: RTL
==================

// Module: mux_nto1_pipe
// PURPOSE
//   Parametrised N-to-1 datapath mux with a registered output stage and a 2-entry
//   skid buffer under a valid/ready handshake. Used where core operand/writeback
//   selection crosses a stall-able pipeline boundary. Out-of-range selects are
//   flagged and output zero, never X. A synchronous flush kills in-flight data on
//   branch redirect.
// PARAMETERS
//   DATAWIDTH   32  width of each data input and of out_data
//   NUM_INPUTS  4   number of selectable inputs, >=2
//   SEL_WIDTH   2   select width; must be >= $clog2(NUM_INPUTS)
// PORTS
//   clk        in   1                     rising-edge clock
//   rst_n      in   1                     asynchronous active-low reset
//   in_data    in   NUM_INPUTS*DATAWIDTH  packed inputs; input i = [i*DATAWIDTH +: DATAWIDTH]
//   in_sel     in   SEL_WIDTH             binary select, sampled on accept
//   in_valid   in   1                     upstream beat valid
//   in_ready   out  1                     block can accept; registered, equals !skid_valid
//   flush      in   1                     synchronous kill of all held beats
//   out_data   out  DATAWIDTH             selected data, registered
//   out_sel    out  SEL_WIDTH             select that produced out_data
//   out_err    out  1                     out_sel >= NUM_INPUTS; out_data is 0
//   out_valid  out  1                     out_data/out_sel/out_err valid
//   out_ready  in   1                     downstream accepts when out_valid & out_ready
// BEHAVIOUR
//   - Reset (rst_n low, async): out_valid=0, out_data=0, out_sel=0, out_err=0,
//     in_ready=1, skid empty. Inputs are ignored while rst_n is low.
//   - Accept  = in_valid & in_ready. Deliver = out_valid & out_ready.
//   - Select: sel < NUM_INPUTS gives data = input[sel] and err = 0.
//     Otherwise data = 0 and err = 1. The select is evaluated at accept and
//     stored with the beat.
//   - Latency: 1 cycle. A beat accepted at edge k is presented on out_* after
//     edge k when the output stage is empty or draining. No combinational path
//     exists from in_* to out_* or from out_ready to in_ready.
//   - States, encoded by {skid_valid, out_valid}:
//     EMPTY (00)
//       -> ONE on accept.
//     ONE (01)
//       - Accept and deliver: the new beat replaces the output stage.
//       - Accept without deliver: the new beat goes to skid -> FULL.
//       - Deliver without accept: -> EMPTY.
//     FULL (11)
//       - in_ready=0.
//       - On deliver, skid moves to the output stage -> ONE.
//   - in_ready goes low the cycle after skid fills, and high the cycle after skid
//     drains. The skid exists so that the one beat accepted in the same cycle
//     in_ready registers low is not lost.
//   - Ordering: strict FIFO. No beat is dropped or duplicated except by flush.
//   - out_* hold stable while out_valid & !out_ready.
//   - Flush: at the next edge, out_valid=0 and skid emptied, in_ready=1.
//     A beat accepted in the flush cycle is discarded.
//     Flush has priority over accept and deliver. A deliver in the flush cycle
//     still counts downstream, because its handshake completed.
//   - Data/sel/err registers only load on accept/transfer. They hold their last
//     value when not valid and are not cleared by flush.
// TESTING
//   1. Reset with DATAWIDTH=32, NUM_INPUTS=4, out_ready=1. Send sels 0,1,2,3 on
//      inputs A5A5_0000+i -> out_data equals input[sel] exactly 1 cycle after each
//      accept; out_err=0; in_ready stays 1.
//   2. NUM_INPUTS=3, SEL_WIDTH=2, sel=3 -> out_data=0, out_err=1, out_sel=3.
//   3. Backpressure: out_ready=0, stream beats 1,2,3 -> beats 1 and 2 accepted;
//      in_ready=0 from the cycle after beat 2; beat 3 is stalled.
//      Release out_ready -> order 1,2,3 is preserved with no loss.
//   4. Flush in FULL with in_valid=1 in the same cycle -> next cycle out_valid=0,
//      in_ready=1, and no flushed beat ever appears on out_*.
//   5. Assert rst_n low mid-stream with the skid full -> all outputs take their
//      reset values immediately, without waiting for a clock edge. After release,
//      the first new beat emerges with 1-cycle latency.
//   6. Random valid/ready/flush for 10k cycles against a scoreboard -> no reorder,
//      no drop/duplicate outside flush, and out_* stable under stall.

Source files
------------

// File: rtl/mux_nto1_pipe_if.sv
// Handshake bundle for mux_nto1_pipe: upstream select/data beat, flush, and
// the registered downstream beat with its out-of-range flag.
interface mux_nto1_pipe_if #(
   parameter int DATAWIDTH  = 32,
   parameter int NUM_INPUTS = 4,
   parameter int SEL_WIDTH  = 2
);
   logic [NUM_INPUTS*DATAWIDTH-1:0] in_data;
   logic [SEL_WIDTH-1:0]            in_sel;
   logic                            in_valid;
   logic                            in_ready;
   logic                            flush;
   logic [DATAWIDTH-1:0]            out_data;
   logic [SEL_WIDTH-1:0]            out_sel;
   logic                            out_err;
   logic                            out_valid;
   logic                            out_ready;

   modport master (
      output in_data, in_sel, in_valid, flush, out_ready,
      input  in_ready, out_data, out_sel, out_err, out_valid
   );

   modport slave (
      input  in_data, in_sel, in_valid, flush, out_ready,
      output in_ready, out_data, out_sel, out_err, out_valid
   );
endinterface

// File: rtl/mux_nto1_pipe.sv
// N-to-1 mux with a registered output stage and a 2-entry skid buffer.
// Out-of-range selects produce zero data with out_err set.
module mux_nto1_pipe #(
   parameter int DATAWIDTH  = 32,
   parameter int NUM_INPUTS = 4,
   parameter int SEL_WIDTH  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   mux_nto1_pipe_if.slave     bus
);
   localparam int NUM_SLOTS = 1 << SEL_WIDTH;

   // State bits double as the handshake flags: [1] = skid_valid, [0] = out_valid.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } state_t;

   state_t               state_reg;
   logic [DATAWIDTH-1:0] out_data_reg;
   logic [SEL_WIDTH-1:0] out_sel_reg;
   logic                 out_err_reg;
   logic [DATAWIDTH-1:0] skid_data_reg;
   logic [SEL_WIDTH-1:0] skid_sel_reg;
   logic                 skid_err_reg;

   // Every select code maps to a slot, so unused codes read as zero, never X.
   logic [DATAWIDTH-1:0] slot_data [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] slot_err;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         if (gi < NUM_INPUTS) begin : g_real
            assign slot_data[gi] = bus.in_data[gi*DATAWIDTH +: DATAWIDTH];
            assign slot_err[gi]  = 1'b0;
         end else begin : g_pad
            assign slot_data[gi] = '0;
            assign slot_err[gi]  = 1'b1;
         end
      end
   endgenerate

   logic [DATAWIDTH-1:0] mux_data;
   logic                 mux_err;
   logic                 accept;
   logic                 deliver;

   assign mux_data = slot_data[bus.in_sel];
   assign mux_err  = slot_err[bus.in_sel];

   assign bus.in_ready  = ~state_reg[1];
   assign bus.out_valid = state_reg[0];
   assign bus.out_data  = out_data_reg;
   assign bus.out_sel   = out_sel_reg;
   assign bus.out_err   = out_err_reg;

   assign accept  = bus.in_valid & ~state_reg[1];
   assign deliver = state_reg[0] & bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= EMPTY;
         out_data_reg  <= '0;
         out_sel_reg   <= '0;
         out_err_reg   <= 1'b0;
         skid_data_reg <= '0;
         skid_sel_reg  <= '0;
         skid_err_reg  <= 1'b0;
      end else if (bus.flush) begin
         // Payload registers keep their contents; only validity is killed.
         state_reg <= EMPTY;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (accept) begin
                  out_data_reg <= mux_data;
                  out_sel_reg  <= bus.in_sel;
                  out_err_reg  <= mux_err;
                  state_reg    <= ONE;
               end
            end
            ONE: begin
               if (accept && deliver) begin
                  out_data_reg <= mux_data;
                  out_sel_reg  <= bus.in_sel;
                  out_err_reg  <= mux_err;
               end else if (accept) begin
                  skid_data_reg <= mux_data;
                  skid_sel_reg  <= bus.in_sel;
                  skid_err_reg  <= mux_err;
                  state_reg     <= FULL;
               end else if (deliver) begin
                  state_reg <= EMPTY;
               end
            end
            FULL: begin
               if (deliver) begin
                  out_data_reg <= skid_data_reg;
                  out_sel_reg  <= skid_sel_reg;
                  out_err_reg  <= skid_err_reg;
                  state_reg    <= ONE;
               end
            end
            default: state_reg <= EMPTY;
         endcase
      end
   end
endmodule
